// File: rtl/fuzzy_wavelet_mac.sv
// fuzzy_wavelet_mac: TAPS-deep wavelet convolution engine with run-time loadable
// coefficients, one time-multiplexed MAC, arithmetic output scaling with saturation,
// a one-deep event pending slot and a sticky overrun flag.
module fuzzy_wavelet_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAPS   = 16,
    parameter int unsigned OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_data_clk,
    input  logic [DATA_W-1:0] i_value,
    input  logic [7:0]        i_select,
    output logic [OUT_W-1:0]  o_out,
    output logic              o_valid,
    output logic              o_active,
    output logic              o_overrun
);

    localparam int unsigned KW     = $clog2(TAPS);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
    localparam logic [KW-1:0] LAST_K = KW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic r_sync1, r_sync2, r_sync3;

    logic              r_pend_full;
    logic [DATA_W-1:0] r_pend_value;
    logic [3:0]        r_pend_sel;   // {load flag, shift[2:0]}

    logic signed [DATA_W-1:0] r_d [TAPS];
    logic signed [DATA_W-1:0] r_c [TAPS];
    logic [KW-1:0]            r_ptr;
    logic [KW-1:0]            r_k;
    logic [2:0]               r_shift;
    logic signed [ACC_W-1:0]  r_acc;
    logic [OUT_W-1:0]         r_out;
    logic                     r_overrun;

    logic              w_event;
    logic              w_proc_pend;
    logic              w_proc_new;
    logic              w_proc;
    logic [DATA_W-1:0] w_proc_value;
    logic [3:0]        w_proc_sel;
    logic              w_start;
    logic              w_load;
    logic              w_pend_store;
    logic              w_drop;
    logic              w_last_k;

    logic signed [PROD_W-1:0] w_c_ext;
    logic signed [PROD_W-1:0] w_d_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [OUT_W-1:0]         w_sat;
    logic                     w_unused_sel;

    assign w_unused_sel = ^i_select[3:0];

    // Event routing: a queued event always goes before a fresh one; a fresh event that
    // finds the slot occupied is lost.
    always_comb begin
        w_event      = r_sync2 & ~r_sync3;
        w_proc_pend  = (r_state == StIdle) && r_pend_full;
        w_proc_new   = (r_state == StIdle) && !r_pend_full && w_event;
        w_proc       = w_proc_pend | w_proc_new;
        w_proc_value = w_proc_pend ? r_pend_value : i_value;
        w_proc_sel   = w_proc_pend ? r_pend_sel : i_select[7:4];
        w_start      = w_proc && !w_proc_sel[3];
        w_load       = w_proc && w_proc_sel[3];
        w_pend_store = w_event && !w_proc_new && !r_pend_full;
        w_drop       = w_event && r_pend_full;
        w_last_k     = (r_k == LAST_K);
    end

    // MAC datapath: one product per ACCUM cycle, then scale and clamp the final sum.
    always_comb begin
        w_c_ext    = PROD_W'(r_c[r_k]);
        w_d_ext    = PROD_W'(r_d[r_k]);
        w_prod     = w_c_ext * w_d_ext;
        w_acc_next = r_acc + ACC_W'(w_prod);
        w_shifted  = w_acc_next >>> r_shift;
        w_sat      = w_shifted[OUT_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: IDLE -> ACCUM on a processed sample, TAPS MAC cycles, one DONE cycle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start) w_state_next = StAccum;
            StAccum: if (w_last_k) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Synchroniser, pending slot, delay line, coefficient store, accumulator and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_pend_full  <= 1'b0;
            r_pend_value <= '0;
            r_pend_sel   <= '0;
            r_ptr        <= '0;
            r_k          <= '0;
            r_shift      <= '0;
            r_acc        <= '0;
            r_out        <= '0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_d[i] <= '0;
                r_c[i] <= '0;
            end
            r_c[0] <= DATA_W'(1);
        end else begin
            r_sync1 <= i_data_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            if (w_start) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    r_d[i] <= r_d[i-1];
                end
                r_d[0]  <= w_proc_value;
                r_shift <= w_proc_sel[2:0];
                r_acc   <= '0;
                r_k     <= '0;
            end

            if (w_load) begin
                r_c[r_ptr] <= w_proc_value;
                r_ptr      <= (r_ptr == LAST_K) ? '0 : r_ptr + KW'(1);
            end

            if (r_state == StAccum) begin
                r_acc <= w_acc_next;
                r_k   <= r_k + KW'(1);
                // Result is registered as ACCUM ends so it is on o_out during the DONE pulse.
                if (w_last_k) begin
                    r_out <= w_sat;
                end
            end

            if (w_proc_pend) begin
                r_pend_full <= 1'b0;
            end else if (w_pend_store) begin
                r_pend_full  <= 1'b1;
                r_pend_value <= i_value;
                r_pend_sel   <= i_select[7:4];
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_out     = r_out;
    assign o_valid   = (r_state == StDone);
    assign o_active  = (r_state == StAccum);
    assign o_overrun = r_overrun;

endmodule
